// File: rtl/fifo_bank.sv
// Four independent circular-buffer FIFO lanes with occupancy flags and registered pop data.
// Define FIFO_BANK_ERR_EN to build the sticky per-lane overflow/underflow flag; otherwise error is tied low.

module fifo_bank_lane #(
  parameter int DATA_W    = 6,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              vld_o,
  output logic              empty_o,
  output logic              afull_o,
  output logic              full_o,
  output logic              err_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              vld_q;
  logic              push_ok, pop_ok;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign afull_o = (cnt_q >= CW'(AF_THRESH));

  // A full lane still takes a push when the same edge pops; an empty lane never reads through.
  assign pop_ok  = pop_i && !empty_o && !reset;
  assign push_ok = push_i && (!full_o || pop_ok) && !reset;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q + CW'(push_ok) - CW'(pop_ok);
    dout_d = dout_q;
    if (push_ok) wptr_d = wptr_q + 1'b1;
    if (pop_ok) begin
      rptr_d = rptr_q + 1'b1;
      dout_d = mem[rptr_q];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      dout_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
      vld_q  <= pop_ok;
    end
  end

  // Storage is never cleared; a slot is only readable once occupancy covers it.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr_q] <= din_i;
  end

  assign dout_o = dout_q;
  assign vld_o  = vld_q;

`ifdef FIFO_BANK_ERR_EN
  logic err_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      err_q <= 1'b0;
    else if ((pop_i && empty_o) || (push_i && full_o && !pop_i))
      err_q <= 1'b1;
  end
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif
endmodule

module fifo_bank #(
  parameter int DATA_W    = 6,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        push,
  input  logic [3:0]        pop,
  input  logic [DATA_W-1:0] data_in0,
  input  logic [DATA_W-1:0] data_in1,
  input  logic [DATA_W-1:0] data_in2,
  input  logic [DATA_W-1:0] data_in3,
  output logic [DATA_W-1:0] data_out0,
  output logic [DATA_W-1:0] data_out1,
  output logic [DATA_W-1:0] data_out2,
  output logic [DATA_W-1:0] data_out3,
  output logic [3:0]        valid_out,
  output logic [3:0]        emptyFIFO,
  output logic [3:0]        almost_fullFIFO,
  output logic [3:0]        fullFIFO,
  output logic [3:0]        error
);
  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0][DATA_W-1:0] din, dout;

  assign din       = {data_in3, data_in2, data_in1, data_in0};
  assign data_out0 = dout[0];
  assign data_out1 = dout[1];
  assign data_out2 = dout[2];
  assign data_out3 = dout[3];

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    fifo_bank_lane #(
      .DATA_W   (DATA_W),
      .DEPTH    (DEPTH),
      .AF_THRESH(AF_THRESH)
    ) u_lane (
      .clk    (clk),
      .reset  (reset),
      .push_i (push[g]),
      .pop_i  (pop[g]),
      .din_i  (din[g]),
      .dout_o (dout[g]),
      .vld_o  (valid_out[g]),
      .empty_o(emptyFIFO[g]),
      .afull_o(almost_fullFIFO[g]),
      .full_o (fullFIFO[g]),
      .err_o  (error[g])
    );
  end
endmodule

// File: doc/fifo_bank.md
FIFO_BANK -- requirements
Module: fifo_bank

Interface
REQ-001 Parameter DATA_W, default 6: width of one FIFO entry.
REQ-002 Parameter DEPTH, default 8: entries per lane; SHALL be a power of two, 4..32.
REQ-003 Parameter AF_THRESH, default 6: occupancy at which almost_full asserts; 1 <= AF_THRESH <= DEPTH.
REQ-004 clk  input  1: single clock; all state updates on the rising edge.
REQ-005 reset  input  1: asynchronous, active-high; clears all lane state.
REQ-006 push  input  4: per-lane write request; bit i targets lane i.
REQ-007 pop  input  4: per-lane read request from the arbiter; bit i targets lane i.
REQ-008 data_in0..data_in3  input  DATA_W each: write data for lanes 0..3.
REQ-009 data_out0..data_out3  output  DATA_W each: registered read data for lanes 0..3.
REQ-010 valid_out  output  4: bit i high for one cycle when data_outi carries a newly popped word.
REQ-011 emptyFIFO  output  4: bit i high when lane i occupancy == 0.
REQ-012 almost_fullFIFO  output  4: bit i high when lane i occupancy >= AF_THRESH.
REQ-013 fullFIFO  output  4: bit i high when lane i occupancy == DEPTH.
REQ-014 error  output  4: sticky per-lane overflow/underflow flag; present only per REQ-031.

Function
REQ-015 Each lane SHALL be an independent circular buffer with write pointer, read pointer and occupancy counter of width log2(DEPTH)+1.
REQ-016 Pointers SHALL wrap from DEPTH-1 to 0 with no gap or skipped entry.
REQ-017 Push on lane i with fullFIFO[i]=0 SHALL write data_ini at the write pointer and advance it on the same edge.
REQ-018 Pop on lane i with emptyFIFO[i]=0 SHALL load data_outi from the read pointer and advance it on the same edge; valid_out[i] SHALL be high the following cycle; latency pop-to-data is one cycle.
REQ-019 data_outi SHALL hold its last value when no pop is accepted; valid_out[i] SHALL be low.
REQ-020 Simultaneous push and pop on a non-empty, non-full lane SHALL both be accepted; occupancy unchanged.
REQ-021 Simultaneous push and pop on a full lane SHALL both be accepted; occupancy stays DEPTH.
REQ-022 Simultaneous push and pop on an empty lane: push accepted, pop ignored (no read-through); occupancy becomes 1; counts as underflow.
REQ-023 Push on a full lane without pop SHALL be dropped; contents and pointers unchanged; counts as overflow.
REQ-024 Pop on an empty lane SHALL be ignored; data_outi unchanged; valid_out[i] low; counts as underflow.
REQ-025 emptyFIFO, almost_fullFIFO, fullFIFO SHALL be decoded from registered occupancy, reflecting the edge's operations in the cycle after that edge.
REQ-026 Lanes SHALL never interact; any combination of the 8 request bits is legal every cycle.

Reset
REQ-027 While reset is high: all pointers and counters 0, data_out0..3 = 0, valid_out = 0, error = 0, emptyFIFO = 4'b1111, almost_fullFIFO = 0, fullFIFO = 0.
REQ-028 Reset SHALL act immediately, without a clock edge, including mid-operation; stored entries are discarded.
REQ-029 push/pop SHALL be ignored on any edge where reset is high; first accepted operation is on the first edge after deassertion.
REQ-030 Storage array contents need not be cleared; they SHALL never be observable before being written.

Configuration
REQ-031 Macro FIFO_BANK_ERR_EN defined: error[i] sets on the edge of any overflow (REQ-023) or underflow (REQ-022, REQ-024) on lane i and stays set until reset.
REQ-032 Macro FIFO_BANK_ERR_EN undefined: error port present, tied to 4'b0000; no error logic synthesized; all other behaviour identical.

Verification
REQ-033 Reset high then low -> emptyFIFO=4'b1111, almost_fullFIFO=0, fullFIFO=0, valid_out=0, data_out0..3=0.
REQ-034 Push 6 words 0x01..0x06 into lane 3 -> almost_fullFIFO=4'b1000 after 6th edge; pop 6 -> data_out3 = 0x01..0x06 in order, each with valid_out[3]=1, then emptyFIFO[3]=1.
REQ-035 Fill lane 0 to 8, push 0x3F without pop -> fullFIFO[0]=1, word dropped, error[0]=1 (ERR_EN); subsequent pops return the original 8 words.
REQ-036 Lane 1 full, push 0x2A with pop, repeated 12 cycles -> occupancy stays 8, fullFIFO[1]=1, data order preserved across pointer wrap.
REQ-037 Pop lane 2 while empty, and push+pop lane 2 while empty -> valid_out[2]=0, occupancy 1 after second, error[2]=1 (ERR_EN) / 0 (no macro).
REQ-038 Assert reset asynchronously with lanes 0..3 at occupancy 5 -> flags return to reset values before next clock edge; next pop on any lane ignored.
